// File: rtl/tinyalu_cmd_master.sv
`default_nettype none
// ============================================================================
// tinyalu_cmd_master : queued start/done initiator driving one TinyALU
// Optional build macro: TINYALU_MASTER_STATS_EN (adds stat_ops/stat_timeouts)
// Revision: 1.0
// ============================================================================
module tinyalu_cmd_master #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
`ifdef TINYALU_MASTER_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_timeouts
`endif
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W:0]   C_FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [18:0]      r_mem [CMD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [18:0] w_head;
  logic [7:0]  w_head_a;
  logic [7:0]  w_head_b;
  logic [2:0]  w_head_op;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL_CNT);
  assign cmd_ready = !w_full && !reset;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_a  = w_head[18:11];
  assign w_head_b  = w_head[10:3];
  assign w_head_op = w_head[2:0];
  assign busy      = !w_empty || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_op};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tmr      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            if (w_head_op == 3'b000) begin
              r_state <= S_IDLE;
            end else if (w_head_op <= 3'b100) begin
              alu_a   <= w_head_a;
              alu_b   <= w_head_b;
              alu_op  <= w_head_op;
              r_state <= S_ISSUE;
            end else begin
              // Illegal opcodes are answered directly; the ALU never sees them.
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              rsp_op     <= w_head_op;
              rsp_valid  <= 1'b1;
              r_state    <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          alu_start <= 1'b1;
          r_tmr     <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            r_state    <= S_RESP;
          end else if (r_tmr == C_TMR_LAST) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            r_state    <= S_RESP;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_GAP;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TINYALU_MASTER_STATS_EN
  logic w_rsp_fire;
  assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

  // A failed response carrying a legal opcode can only come from a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ops      <= '0;
      stat_timeouts <= '0;
    end else if (w_rsp_fire) begin
      if (!rsp_err && (stat_ops != 16'hFFFF)) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (rsp_err && (rsp_op <= 3'b100) && (stat_timeouts != 16'hFFFF)) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_tinyalu_cmd_master : directed self-checking bench with a TinyALU responder
// Revision: 1.0
// ============================================================================
module tb_tinyalu_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;
`ifdef TINYALU_MASTER_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_timeouts;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 1;
  logic        manual_done = 1'b0;
  logic        model_done = 1'b0;
  logic [15:0] model_res = '0;
  int          model_cnt = 0;
  bit          model_fired = 1'b0;
  int          start_cycles = 0;

  logic [7:0]  bp_a   [5] = '{8'h12, 8'hF0, 8'hF0, 8'h80, 8'hFF};
  logic [7:0]  bp_b   [5] = '{8'h34, 8'h3C, 8'h3C, 8'h80, 8'h0F};
  logic [2:0]  bp_op  [5] = '{3'd1,  3'd2,  3'd3,  3'd1,  3'd2};
  logic [15:0] bp_exp [5] = '{16'h0046, 16'h0030, 16'h00CC, 16'h0100, 16'h000F};

  tinyalu_cmd_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
`ifdef TINYALU_MASTER_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  assign alu_done   = model_done | manual_done;
  assign alu_result = model_res;

  // ALU responder: raise done for one cycle `lat` cycles into a start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (alu_start) start_cycles++;
      if (alu_start && !model_fired) begin
        model_cnt++;
        if (lat != 0 && model_cnt == lat) begin
          model_done  = 1'b1;
          model_fired = 1'b1;
          case (alu_op)
            3'd1:    model_res = {8'h00, alu_a} + {8'h00, alu_b};
            3'd2:    model_res = {8'h00, alu_a & alu_b};
            3'd3:    model_res = {8'h00, alu_a ^ alu_b};
            3'd4:    model_res = alu_a * alu_b;
            default: model_res = 16'h0000;
          endcase
        end else begin
          model_done = 1'b0;
        end
      end else begin
        model_done = 1'b0;
        if (!alu_start) begin
          model_cnt   = 0;
          model_fired = 1'b0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the command is taken.
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("push_rdy", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int budget, output logic [15:0] r, output logic [2:0] o,
                         output logic e);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("rsp_seen", 32'(rsp_valid), 32'd1);
    r = rsp_result;
    o = rsp_op;
    e = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_val("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!alu_start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("start_seen", 32'(alu_start), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [2:0]  o;
    logic        e;
    int          n;
    int          s0;
    bit          seen;

    // Reset values, sampled while reset is still high
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_val("rst_alu_start", 32'(alu_start), 32'd0);
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rsp", {12'd0, rsp_err, rsp_op, rsp_result}, 32'd0);
    check_val("rst_alu_ops", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Add FF+01 with one-cycle ALU latency; start appears 2 cycles after head
    lat = 1;
    push(8'hFF, 8'h01, 3'd1);
    @(negedge clk);
    check_val("add_start_early", 32'(alu_start), 32'd0);
    @(negedge clk);
    check_val("add_start", 32'(alu_start), 32'd1);
    check_val("add_ops", {13'd0, alu_a, alu_b, alu_op}, {13'd0, 8'hFF, 8'h01, 3'd1});
    @(negedge clk);
    check_val("add_start_drop", 32'(alu_start), 32'd0);
    check_val("add_rsp_valid", 32'(rsp_valid), 32'd1);
    get_rsp(20, r, o, e);
    check_val("add_result", 32'(r), 32'h0100);
    check_val("add_op", 32'(o), 32'd1);
    check_val("add_err", 32'(e), 32'd0);

    // Mul FF*FF with three-cycle latency; start held steady through WAIT
    lat = 3;
    push(8'hFF, 8'hFF, 3'd4);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val("mul_hold", 32'(alu_start), 32'd1);
      check_val("mul_ops", {13'd0, alu_a, alu_b, alu_op}, {13'd0, 8'hFF, 8'hFF, 3'd4});
      @(negedge clk);
    end
    check_val("mul_start_drop", 32'(alu_start), 32'd0);
    check_val("mul_rsp_valid", 32'(rsp_valid), 32'd1);
    get_rsp(20, r, o, e);
    check_val("mul_result", 32'(r), 32'hFE01);
    check_val("mul_op", 32'(o), 32'd4);
    check_val("mul_err", 32'(e), 32'd0);

    // Back-pressure: head command goes in flight, remaining four fill the FIFO
    lat = 1;
    for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i], bp_op[i]);
    check_val("bp_full", 32'(cmd_ready), 32'd0);
    check_val("bp_busy", 32'(busy), 32'd1);
    check_val("bp_rsp_held", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      get_rsp(40, r, o, e);
      check_val($sformatf("bp_result%0d", i), 32'(r), 32'(bp_exp[i]));
      check_val($sformatf("bp_op%0d", i), 32'(o), 32'(bp_op[i]));
      check_val($sformatf("bp_err%0d", i), 32'(e), 32'd0);
    end
    check_val("bp_ready_back", 32'(cmd_ready), 32'd1);

    // Timeout: ALU never answers, start must stay high for exactly 32 cycles
    lat = 0;
    push(8'h05, 8'h06, 3'd1);
    wait_start(20);
    n = 0;
    while (alu_start && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val("to_len", 32'(n), 32'd32);
    check_val("to_rsp_valid", 32'(rsp_valid), 32'd1);
    get_rsp(20, r, o, e);
    check_val("to_result", 32'(r), 32'h0000);
    check_val("to_err", 32'(e), 32'd1);
    check_val("to_op", 32'(o), 32'd1);
`ifdef TINYALU_MASTER_STATS_EN
    check_val("stat_timeouts", 32'(stat_timeouts), 32'd1);
    check_val("stat_ops", 32'(stat_ops), 32'd7);
`endif

    // Illegal op then no-op: one error response, ALU untouched
    s0 = start_cycles;
    push(8'h01, 8'h02, 3'd6);
    push(8'h03, 8'h04, 3'd0);
    get_rsp(20, r, o, e);
    check_val("ill_err", 32'(e), 32'd1);
    check_val("ill_op", 32'(o), 32'd6);
    check_val("ill_result", 32'(r), 32'h0000);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check_val("noop_no_rsp", 32'(seen), 32'd0);
    check_val("ill_no_start", 32'(start_cycles - s0), 32'd0);
    check_val("ill_idle", 32'(busy), 32'd0);
`ifdef TINYALU_MASTER_STATS_EN
    check_val("stat_ops_ill", 32'(stat_ops), 32'd7);
    check_val("stat_to_ill", 32'(stat_timeouts), 32'd1);
`endif

    // Reset mid-WAIT with another command queued; late done must be ignored
    lat = 0;
    push(8'h07, 8'h08, 3'd1);
    wait_start(20);
    @(negedge clk);
    push(8'h09, 8'h0A, 3'd2);
    reset = 1'b1;
    @(negedge clk);
    check_val("mrst_start", 32'(alu_start), 32'd0);
    check_val("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (rsp_valid || alu_start) seen = 1'b1;
      @(negedge clk);
    end
    check_val("mrst_late_done", 32'(seen), 32'd0);
    check_val("mrst_idle", 32'(busy), 32'd0);
`ifdef TINYALU_MASTER_STATS_EN
    check_val("stat_ops_rst", 32'(stat_ops), 32'd0);
    check_val("stat_to_rst", 32'(stat_timeouts), 32'd0);
`endif

    // Recovery after reset
    lat = 1;
    push(8'h10, 8'h20, 3'd1);
    get_rsp(20, r, o, e);
    check_val("rec_result", 32'(r), 32'h0030);
    check_val("rec_err", 32'(e), 32'd0);
`ifdef TINYALU_MASTER_STATS_EN
    check_val("stat_ops_rec", 32'(stat_ops), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
